// File: rtl/ball_motion_controller.sv
// ============================================================================
// Module   : ball_motion_controller
// Purpose  : Pong ball stepper with wall/paddle bounces and miss reporting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_motion_controller #(
    parameter int SCREEN_W   = 320,
    parameter int SCREEN_H   = 240,
    parameter int X_WIDTH    = 9,
    parameter int Y_WIDTH    = 8,
    parameter int BALL_SIZE  = 4,
    parameter int SPEED      = 2,
    parameter int PADDLE_H   = 32,
    parameter int PADDLE_W   = 4,
    parameter int PADDLE_L_X = 8,
    parameter int PADDLE_R_X = 308,
    parameter int HOLD_TICKS = 30
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic [Y_WIDTH-1:0] paddleLeftY,
    input  logic [Y_WIDTH-1:0] paddleRightY,
    output logic [X_WIDTH-1:0] ballX,
    output logic [Y_WIDTH-1:0] ballY,
    output logic               running,
    output logic               missLeft,
    output logic               missRight
);

    localparam int c_XE = X_WIDTH + 1;
    localparam int c_YE = Y_WIDTH + 1;
    localparam int c_HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [X_WIDTH-1:0] c_CX = X_WIDTH'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [Y_WIDTH-1:0] c_CY = Y_WIDTH'((SCREEN_H - BALL_SIZE) / 2);

    localparam logic [X_WIDTH:0] c_SPEED_X = c_XE'(SPEED);
    localparam logic [X_WIDTH:0] c_BALL_X  = c_XE'(BALL_SIZE);
    localparam logic [X_WIDTH:0] c_R_EDGE  = c_XE'(PADDLE_R_X);
    localparam logic [X_WIDTH:0] c_L_THR   = c_XE'(PADDLE_L_X + PADDLE_W + SPEED);
    localparam logic [X_WIDTH-1:0] c_R_STOP = X_WIDTH'(PADDLE_R_X - BALL_SIZE);
    localparam logic [X_WIDTH-1:0] c_L_STOP = X_WIDTH'(PADDLE_L_X + PADDLE_W);

    localparam logic [Y_WIDTH:0] c_SPEED_Y = c_YE'(SPEED);
    localparam logic [Y_WIDTH:0] c_BALL_Y  = c_YE'(BALL_SIZE);
    localparam logic [Y_WIDTH:0] c_PH_Y    = c_YE'(PADDLE_H);
    localparam logic [Y_WIDTH:0] c_Y_MAX   = c_YE'(SCREEN_H - BALL_SIZE);

    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MOVE  = 2'd1,
        S_SCORE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_dirX;     // 1 = right
    logic              r_dirY;     // 1 = down
    logic              r_serve;    // 1 = next serve goes right
    logic [c_HW-1:0]   r_hold;

    logic [X_WIDTH:0]   w_x;
    logic [Y_WIDTH:0]   w_y;
    logic [Y_WIDTH:0]   w_ny;
    logic [X_WIDTH-1:0] w_nx;
    logic               w_ndx;
    logic               w_ndy;
    logic               w_hit_l;
    logic               w_hit_r;
    logic               w_miss_l;
    logic               w_miss_r;

    // Next-tick motion; the zero-extended copies keep compares free of wrap.
    always_comb begin
        w_x      = {1'b0, ballX};
        w_y      = {1'b0, ballY};
        w_ny     = w_y;
        w_ndy    = r_dirY;
        w_nx     = ballX;
        w_ndx    = r_dirX;
        w_miss_l = 1'b0;
        w_miss_r = 1'b0;

        if (r_dirY) begin
            if (w_y + c_SPEED_Y >= c_Y_MAX) begin
                w_ny  = c_Y_MAX;
                w_ndy = 1'b0;
            end else begin
                w_ny = w_y + c_SPEED_Y;
            end
        end else if (w_y < c_SPEED_Y) begin
            w_ny  = '0;
            w_ndy = 1'b1;
        end else begin
            w_ny = w_y - c_SPEED_Y;
        end

        w_hit_r = (w_ny + c_BALL_Y > {1'b0, paddleRightY}) &&
                  (w_ny < {1'b0, paddleRightY} + c_PH_Y);
        w_hit_l = (w_ny + c_BALL_Y > {1'b0, paddleLeftY}) &&
                  (w_ny < {1'b0, paddleLeftY} + c_PH_Y);

        if (r_dirX) begin
            if (w_x + c_SPEED_X + c_BALL_X >= c_R_EDGE) begin
                w_nx = c_R_STOP;
                if (w_hit_r) w_ndx    = 1'b0;
                else         w_miss_r = 1'b1;
            end else begin
                w_nx = X_WIDTH'(w_x + c_SPEED_X);
            end
        end else if (w_x <= c_L_THR) begin
            w_nx = c_L_STOP;
            if (w_hit_l) w_ndx    = 1'b1;
            else         w_miss_l = 1'b1;
        end else begin
            w_nx = X_WIDTH'(w_x - c_SPEED_X);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_dirX    <= 1'b1;
            r_dirY    <= 1'b1;
            r_serve   <= 1'b1;
            r_hold    <= '0;
            ballX     <= c_CX;
            ballY     <= c_CY;
            running   <= 1'b0;
            missLeft  <= 1'b0;
            missRight <= 1'b0;
        end else begin
            missLeft  <= 1'b0;
            missRight <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    ballX <= c_CX;
                    ballY <= c_CY;
                    if (start) begin
                        r_state <= S_MOVE;
                        running <= 1'b1;
                        r_dirX  <= r_serve;
                        r_serve <= ~r_serve;
                    end
                end
                S_MOVE: begin
                    if (tick) begin
                        ballX     <= w_nx;
                        ballY     <= Y_WIDTH'(w_ny);
                        r_dirX    <= w_ndx;
                        r_dirY    <= w_ndy;
                        missLeft  <= w_miss_l;
                        missRight <= w_miss_r;
                        if (w_miss_l || w_miss_r) begin
                            r_state <= S_SCORE;
                            running <= 1'b0;
                        end
                    end
                end
                S_SCORE: begin
                    if (tick) begin
                        if (r_hold == c_HOLD_LAST) begin
                            r_hold  <= '0;
                            ballX   <= c_CX;
                            ballY   <= c_CY;
                            r_state <= S_IDLE;
                        end else begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ball_motion_controller.sv
// ============================================================================
// Module   : tb_ball_motion_controller
// Purpose  : Directed plus randomized checks against a behavioural ball model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ball_motion_controller;

    localparam int W    = 320;
    localparam int H    = 240;
    localparam int B    = 4;
    localparam int SP   = 2;
    localparam int PH   = 32;
    localparam int PW   = 4;
    localparam int PLX  = 8;
    localparam int PRX  = 308;
    localparam int HOLD = 30;
    localparam int CX   = (W - B) / 2;
    localparam int CY   = (H - B) / 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tick  = 1'b0;
    logic       start = 1'b0;
    logic [7:0] paddleLeftY  = 8'd0;
    logic [7:0] paddleRightY = 8'd0;
    logic [8:0] ballX;
    logic [7:0] ballY;
    logic       running;
    logic       missLeft;
    logic       missRight;

    ball_motion_controller #(
        .SCREEN_W(W), .SCREEN_H(H), .X_WIDTH(9), .Y_WIDTH(8),
        .BALL_SIZE(B), .SPEED(SP), .PADDLE_H(PH), .PADDLE_W(PW),
        .PADDLE_L_X(PLX), .PADDLE_R_X(PRX), .HOLD_TICKS(HOLD)
    ) u_dut (
        .clock(clock), .reset(reset), .tick(tick), .start(start),
        .paddleLeftY(paddleLeftY), .paddleRightY(paddleRightY),
        .ballX(ballX), .ballY(ballY), .running(running),
        .missLeft(missLeft), .missRight(missRight)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: position, direction as +1/-1, phase 0=idle 1=move 2=score
    int mx, my, mdx, mdy, mst, mhold, mserve, mmissL, mmissR;
    int pfix_l = 0;
    int pfix_r = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic rn, input logic tk, input logic st,
                              input int pl, input int pr);
        int ny;
        mmissL = 0;
        mmissR = 0;
        if (!rn) begin
            mx = CX; my = CY; mdx = 1; mdy = 1;
            mst = 0; mhold = 0; mserve = 1;
        end else if (mst == 0) begin
            mx = CX; my = CY;
            if (st) begin
                mst = 1;
                mdx = mserve;
                mserve = -mserve;
            end
        end else if (mst == 1) begin
            if (tk) begin
                ny = my + mdy * SP;
                if (ny >= H - B) begin ny = H - B; mdy = -1; end
                else if (ny < 0) begin ny = 0; mdy = 1; end
                if (mdx > 0 && mx + SP + B >= PRX) begin
                    mx = PRX - B;
                    if (ny + B > pr && ny < pr + PH) mdx = -1;
                    else begin mmissR = 1; mst = 2; end
                end else if (mdx < 0 && mx <= PLX + PW + SP) begin
                    mx = PLX + PW;
                    if (ny + B > pl && ny < pl + PH) mdx = 1;
                    else begin mmissL = 1; mst = 2; end
                end else begin
                    mx = mx + mdx * SP;
                end
                my = ny;
            end
        end else begin
            if (tk) begin
                if (mhold == HOLD - 1) begin
                    mhold = 0; mx = CX; my = CY; mst = 0;
                end else begin
                    mhold++;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step(reset, tick, start, int'(paddleLeftY), int'(paddleRightY));
        @(negedge clock);
        check("ballX", 32'(ballX), 32'(mx));
        check("ballY", 32'(ballY), 32'(my));
        check("running", 32'(running), 32'(mst == 1));
        check("missLeft", 32'(missLeft), 32'(mmissL));
        check("missRight", 32'(missRight), 32'(mmissR));
    endtask

    // mode 0: fixed values, 1: track model ball (clamped at 0), 2: random
    task automatic pick_paddles(input int mode);
        int t;
        t = (my > 14) ? my - 14 : 0;
        case (mode)
            0: begin paddleLeftY = 8'(pfix_l); paddleRightY = 8'(pfix_r); end
            1: begin paddleLeftY = 8'(t); paddleRightY = 8'(t); end
            default: begin paddleLeftY = 8'($urandom); paddleRightY = 8'($urandom); end
        endcase
    endtask

    // Paddles are scrambled between ticks since they only matter on the tick cycle.
    task automatic ticks(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            pick_paddles(mode);
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                paddleLeftY  = 8'($urandom);
                paddleRightY = 8'($urandom);
                cycle();
            end
        end
    endtask

    task automatic serve();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        mx = CX; my = CY; mdx = 1; mdy = 1; mst = 0; mhold = 0; mserve = 1;
        mmissL = 0; mmissR = 0;

        // Reset and idle behaviour
        reset = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        check("rst_x", 32'(ballX), 32'd158);
        check("rst_y", 32'(ballY), 32'd118);
        check("rst_run", 32'(running), 32'd0);
        check("rst_miss", 32'({missLeft, missRight}), 32'd0);
        ticks(10, 2);
        check("idle_x", 32'(ballX), 32'd158);
        check("idle_y", 32'(ballY), 32'd118);

        // First serve and movement
        serve();
        check("serve_run", 32'(running), 32'd1);
        check("serve_x", 32'(ballX), 32'd158);
        ticks(1, 1);
        check("t1_x", 32'(ballX), 32'd160);
        check("t1_y", 32'(ballY), 32'd120);
        ticks(5, 1);
        check("t6_x", 32'(ballX), 32'd170);
        check("t6_y", 32'(ballY), 32'd130);

        // Reset mid-MOVE
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        check("rmid_x", 32'(ballX), 32'd158);
        check("rmid_y", 32'(ballY), 32'd118);
        check("rmid_run", 32'(running), 32'd0);

        // Serve goes right again; bottom wall, then right paddle hit
        serve();
        ticks(1, 1);
        check("reserve_x", 32'(ballX), 32'd160);
        ticks(58, 1);
        check("wall_y", 32'(ballY), 32'd236);
        ticks(1, 1);
        check("wall_back_y", 32'(ballY), 32'd234);
        ticks(13, 1);
        check("rhit_x", 32'(ballX), 32'd304);
        ticks(1, 1);
        check("rhit_back_x", 32'(ballX), 32'd302);
        ticks(200, 1);
        check("rally_run", 32'(running), 32'd1);

        // Right miss, hold, re-centre, left serve
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        pfix_l = 0;
        pfix_r = 0;
        serve();
        ticks(72, 0);
        pick_paddles(0);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        check("miss_pulse", 32'(missRight), 32'd1);
        check("miss_x", 32'(ballX), 32'd304);
        check("miss_run", 32'(running), 32'd0);
        cycle();
        check("miss_one_cycle", 32'(missRight), 32'd0);
        ticks(29, 2);
        check("hold_x", 32'(ballX), 32'd304);
        ticks(1, 2);
        check("recentre_x", 32'(ballX), 32'd158);
        check("recentre_y", 32'(ballY), 32'd118);
        serve();
        ticks(1, 2);
        check("left_serve_x", 32'(ballX), 32'd156);

        // Randomized play, including tick+start together and stray resets
        for (int i = 0; i < 2500; i++) begin
            reset = ($urandom_range(0, 399) != 0);
            tick  = ($urandom_range(0, 2) == 0);
            start = ($urandom_range(0, 19) == 0);
            pick_paddles($urandom_range(1, 2));
            cycle();
        end
        reset = 1'b1;
        tick  = 1'b0;
        start = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
